code_verifier: RTL and testbench
================================

Name: code_verifier

Overview:
- Clocked, parametrised successor to the lock's password comparator.
- Compares an entered N-digit code against the stored code serially, one digit per cycle, over a fixed constant-time window.
- Reports the result through a start/done handshake, counts consecutive failures and enforces a timed lockout after too many failures.
- Sits between the keypad entry register bank and the lock actuator/display controller.

Parameters:
- DIGITS, 6: number of code digits (>=1).
- DIGIT_W, 4: bits per digit (BCD default).
- MAX_FAIL, 3: consecutive failures that trigger lockout (>=1).
- LOCK_CYCLES, 1000: lockout duration in clk cycles (>=1).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  request a comparison; sampled only in IDLE
- abort  in  1  cancel an in-progress comparison
- entry  in  DIGITS*DIGIT_W  entered code; digit i = bits [i*DIGIT_W +: DIGIT_W]
- stored  in  DIGITS*DIGIT_W  reference code, same packing
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse; result valid
- match  out  1  result of last completed comparison
- locked  out  1  high during LOCKOUT
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failure count

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. All state is updated on the rising edge of clk.
- Reset values: state=IDLE, busy=0, done=0, match=0, locked=0, fail_cnt=0, digit index=0, lockout counter=0.
- Priority at each edge: rst > abort > normal operation.
- States: IDLE, CMP, RESULT, LOCKOUT.
- IDLE:
  - If start=1 at an edge: latch entry and stored into shadow registers, clear match, set index=0, set the running-equal flag=1, go to CMP.
  - Later changes on entry/stored do not affect a comparison in progress.
- CMP:
  - Each edge: flag <= flag & (shadow_entry digit[index] == shadow_stored digit[index]); index increments.
  - Always runs all DIGITS cycles, with no early exit on mismatch (constant-time).
  - On the edge that compares digit DIGITS-1: go to RESULT, set done=1 and match=final flag.
- Latency: start sampled at edge k -> done=1 and match valid in the cycle following edge k+DIGITS. done is high for exactly one cycle.
- RESULT (single cycle):
  - On match: fail_cnt <= 0; go to IDLE.
  - On mismatch with fail_cnt+1 < MAX_FAIL: fail_cnt increments; go to IDLE.
  - On mismatch with fail_cnt+1 == MAX_FAIL: fail_cnt <= MAX_FAIL; go to LOCKOUT; locked=1; lockout counter loads LOCK_CYCLES-1.
- LOCKOUT:
  - start is ignored.
  - Counter decrements each edge. The edge on which the counter is 0 sets locked=0, clears fail_cnt and returns to IDLE, so locked is high for exactly LOCK_CYCLES cycles.
- start while busy: ignored, not queued.
- abort:
  - In CMP: return to IDLE. No done pulse; match and fail_cnt unchanged.
  - In IDLE, RESULT or LOCKOUT: no effect. Lockout cannot be aborted.
- match holds its value until the next accepted start.
- fail_cnt saturates at MAX_FAIL and never wraps.
- rst asserted mid-CMP or mid-LOCKOUT returns every output to its reset value on that edge.
- Index and lockout counters are sized $clog2 of their ranges (minimum 1 bit).

Test Plan (DIGITS=6, DIGIT_W=4, MAX_FAIL=3, LOCK_CYCLES=8):
1. Correct code: stored=entry=24'h123456, start pulse at edge k -> busy=1 from k; done=1, match=1 in the cycle after edge k+6; fail_cnt=0; back to IDLE one cycle later.
2. Mismatch in last digit: entry=24'h923456 (digit 5 differs), stored=24'h123456 -> done after exactly 6 compare cycles, same as the mismatch-in-digit-0 case; match=0; fail_cnt=1.
3. Lockout: three consecutive wrong codes -> fail_cnt goes 1, 2, 3; locked=1 for exactly 8 cycles; a start pulse during lockout produces no done; then locked=0, fail_cnt=0, and a correct code is accepted.
4. Failure reset by success: two wrong codes followed by a correct one -> fail_cnt goes 1, 2, 0; no lockout.
5. Abort and input stability: abort during CMP cycle 3 -> IDLE, no done, fail_cnt unchanged. Separately, change entry mid-CMP -> result reflects the value latched at start.
6. Reset mid-operation: rst during CMP and during LOCKOUT -> all outputs 0 on the next cycle; start accepted immediately after rst deasserts.

Source files
------------

// File: rtl/code_verifier_if.sv
// Bundle between the keypad register bank (master) and the code verifier (slave).
// Handshake: start is a one-cycle request taken only while busy=0; the result appears as a one-cycle done pulse with match valid alongside it.
interface code_verifier_if #(
  parameter int DIGITS   = 6,
  parameter int DIGIT_W  = 4,
  parameter int MAX_FAIL = 3
) ();
  localparam int W      = DIGITS * DIGIT_W;
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  logic              start;
  logic              abort;
  logic [W-1:0]      entry;
  logic [W-1:0]      stored;
  logic              busy;
  logic              done;
  logic              match;
  logic              locked;
  logic [FAIL_W-1:0] fail_cnt;
  logic [1:0]        dbg_state;

  modport master (
    output start, abort, entry, stored,
    input  busy, done, match, locked, fail_cnt, dbg_state
  );

  modport slave (
    input  start, abort, entry, stored,
    output busy, done, match, locked, fail_cnt, dbg_state
  );
endinterface

// File: rtl/code_verifier.sv
// Constant-time serial code comparator with consecutive-failure counting and timed lockout.
module code_verifier #(
  parameter int DIGITS      = 6,
  parameter int DIGIT_W     = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 1000
) (
  input  logic           clk,
  input  logic           rst,
  code_verifier_if.slave bus
);
  localparam int W      = DIGITS * DIGIT_W;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int LCK_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CMP     = 2'd1,
    S_RESULT  = 2'd2,
    S_LOCKOUT = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      entry_q, entry_d;
  logic [W-1:0]      stored_q, stored_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              eq_q, eq_d;
  logic              match_q, match_d;
  logic              done_q, done_d;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic [LCK_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [DIGIT_W-1:0] cur_entry, cur_stored;
  logic              digit_eq;

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    stored_d   = stored_q;
    idx_d      = idx_q;
    eq_d       = eq_q;
    match_d    = match_q;
    done_d     = 1'b0;
    fail_d     = fail_q;
    lock_cnt_d = lock_cnt_q;
    cur_entry  = entry_q[idx_q*DIGIT_W +: DIGIT_W];
    cur_stored = stored_q[idx_q*DIGIT_W +: DIGIT_W];
    digit_eq   = (cur_entry == cur_stored);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          entry_d  = bus.entry;
          stored_d = bus.stored;
          match_d  = 1'b0;
          idx_d    = '0;
          eq_d     = 1'b1;
          state_d  = S_CMP;
        end
      end
      S_CMP: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          // Every digit is visited regardless of earlier mismatches so timing leaks nothing.
          eq_d  = eq_q & digit_eq;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(DIGITS - 1)) begin
            state_d = S_RESULT;
            done_d  = 1'b1;
            match_d = eq_q & digit_eq;
          end
        end
      end
      S_RESULT: begin
        if (match_q) begin
          fail_d  = '0;
          state_d = S_IDLE;
        end else if (fail_q >= FAIL_W'(MAX_FAIL - 1)) begin
          fail_d     = FAIL_W'(MAX_FAIL);
          lock_cnt_d = LCK_W'(LOCK_CYCLES - 1);
          state_d    = S_LOCKOUT;
        end else begin
          fail_d  = fail_q + FAIL_W'(1);
          state_d = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (lock_cnt_q == '0) begin
          fail_d  = '0;
          state_d = S_IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q - LCK_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      entry_q    <= '0;
      stored_q   <= '0;
      idx_q      <= '0;
      eq_q       <= 1'b0;
      match_q    <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      stored_q   <= stored_d;
      idx_q      <= idx_d;
      eq_q       <= eq_d;
      match_q    <= match_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.locked    = (state_q == S_LOCKOUT);
  assign bus.done      = done_q;
  assign bus.match     = match_q;
  assign bus.fail_cnt  = fail_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_code_verifier.sv
// Directed plus randomized checks of code_verifier against a word-level model of the lock rules.
module tb_code_verifier;
  localparam int DIGITS      = 6;
  localparam int DIGIT_W     = 4;
  localparam int MAX_FAIL    = 3;
  localparam int LOCK_CYCLES = 8;
  localparam int W           = DIGITS * DIGIT_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;
  int   exp_fail    = 0;
  logic exp_locked  = 1'b0;

  code_verifier_if #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .MAX_FAIL(MAX_FAIL)) bus ();

  code_verifier #(
    .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},     32'(bus.busy),     0);
    check({tag, "_done"},     32'(bus.done),     0);
    check({tag, "_match"},    32'(bus.match),    0);
    check({tag, "_locked"},   32'(bus.locked),   0);
    check({tag, "_fail_cnt"}, 32'(bus.fail_cnt), 0);
  endtask

  // Full comparison; e_mid/s_mid are applied right after start is taken and must not matter.
  task automatic do_compare(input logic [W-1:0] e, input logic [W-1:0] s,
                            input logic [W-1:0] e_mid, input logic [W-1:0] s_mid);
    int   n;
    logic exp_m;
    exp_m      = (e == s);
    bus.entry  = e;
    bus.stored = s;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.entry  = e_mid;
    bus.stored = s_mid;
    check("busy_after_start", 32'(bus.busy), 1);
    check("match_cleared", 32'(bus.match), 0);
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("latency", n, DIGITS);
    check("match", 32'(bus.match), 32'(exp_m));
    if (exp_m) exp_fail = 0;
    else if (exp_fail + 1 >= MAX_FAIL) begin
      exp_fail   = MAX_FAIL;
      exp_locked = 1'b1;
    end else exp_fail++;
    tick();
    check("done_one_cycle", 32'(bus.done), 0);
    check("match_hold", 32'(bus.match), 32'(exp_m));
    check("fail_cnt", 32'(bus.fail_cnt), exp_fail);
    check("locked", 32'(bus.locked), 32'(exp_locked));
    check("busy_after_result", 32'(bus.busy), 32'(exp_locked));
  endtask

  task automatic drain_lockout();
    int cnt;
    bit saw_done;
    cnt      = 0;
    saw_done = 0;
    while (bus.locked === 1'b1 && cnt < 50) begin
      if (bus.done === 1'b1) saw_done = 1;
      bus.start = (cnt == 2);
      tick();
      cnt++;
    end
    bus.start = 1'b0;
    check("lockout_len", cnt, LOCK_CYCLES);
    check("no_done_in_lockout", 32'(saw_done), 0);
    exp_locked = 1'b0;
    exp_fail   = 0;
    check("post_lock_fail_cnt", 32'(bus.fail_cnt), 0);
    check("post_lock_busy", 32'(bus.busy), 0);
    check("post_lock_done", 32'(bus.done), 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_fail   = 0;
    exp_locked = 1'b0;
  endtask

  initial begin
    logic [W-1:0] s, e, em, sm;
    int           d;
    int           n;
    bit           saw;

    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.entry  = '0;
    bus.stored = '0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_all_zero("idle");

    // Correct code, then last-digit and first-digit mismatches with equal latency.
    do_compare(24'h123456, 24'h123456, 24'h123456, 24'h123456);
    do_compare(24'h923456, 24'h123456, 24'h923456, 24'h123456);
    do_compare(24'h123457, 24'h123456, 24'h123457, 24'h123456);
    do_compare(24'h000000, 24'h123456, 24'h000000, 24'h123456);
    drain_lockout();
    do_compare(24'h123456, 24'h123456, 24'h123456, 24'h123456);

    // Two failures cleared by a success.
    do_compare(24'h111111, 24'h222222, 24'h111111, 24'h222222);
    do_compare(24'h111112, 24'h222222, 24'h111112, 24'h222222);
    do_compare(24'h222222, 24'h222222, 24'h222222, 24'h222222);

    // Abort in compare cycle 3.
    do_compare(24'h000001, 24'h000002, 24'h000001, 24'h000002);
    bus.entry  = 24'h345678;
    bus.stored = 24'h345678;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_fail_cnt", 32'(bus.fail_cnt), exp_fail);
    check("abort_match", 32'(bus.match), 0);
    saw = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done === 1'b1) saw = 1;
      tick();
    end
    check("abort_no_done", 32'(saw), 0);

    // Inputs changed mid-compare must not alter the latched result.
    do_compare(24'h654321, 24'h654321, 24'h000000, 24'hffffff);
    do_compare(24'h654321, 24'h654320, 24'h777777, 24'h777777);

    // Reset mid-compare, then immediate restart.
    bus.entry  = 24'h999999;
    bus.stored = 24'h999999;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    pulse_reset();
    check_all_zero("rst_cmp");
    do_compare(24'h999999, 24'h999999, 24'h999999, 24'h999999);

    // Reset mid-lockout.
    do_compare(24'h000001, 24'h000000, 24'h000001, 24'h000000);
    do_compare(24'h000001, 24'h000000, 24'h000001, 24'h000000);
    do_compare(24'h000001, 24'h000000, 24'h000001, 24'h000000);
    check("lock_entered", 32'(bus.locked), 1);
    tick();
    tick();
    tick();
    pulse_reset();
    check_all_zero("rst_lock");
    do_compare(24'h424242, 24'h424242, 24'h424242, 24'h424242);

    // Randomized codes: roughly half with one digit corrupted.
    for (int it = 0; it < 24; it++) begin
      s  = W'($urandom);
      e  = s;
      em = W'($urandom);
      sm = W'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom_range(0, DIGITS - 1);
        e[d*DIGIT_W +: DIGIT_W] = e[d*DIGIT_W +: DIGIT_W] + DIGIT_W'($urandom_range(1, 15));
      end
      do_compare(e, s, em, sm);
      if (exp_locked) drain_lockout();
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
